// File: rtl/step_controller_if.sv
// Control/status bundle between the board-facing step controller and its user.
interface step_controller_if;
    logic       step_btn;
    logic       run_sw;
    logic       halt;
    logic       cpu_en;
    logic [1:0] mode;
    logic [7:0] step_count;

    modport master (
        output step_btn,
        output run_sw,
        output halt,
        input  cpu_en,
        input  mode,
        input  step_count
    );

    modport slave (
        input  step_btn,
        input  run_sw,
        input  halt,
        output cpu_en,
        output mode,
        output step_count
    );
endinterface

// File: rtl/step_controller.sv
// Clock-enable generator for the cpu: debounced single-step presses in STEP
// mode, a divided free-running enable in RUN mode, and a sticky HALTED state.
module step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_DIV         = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    step_controller_if.slave bus
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > RUN_DIV) ? DEBOUNCE_CYCLES : RUN_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_STEP   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    logic             btn_s1;
    logic             btn_s2;
    logic             sw_s1;
    logic             sw_s2;
    logic [1:0]       sync_ready;

    logic             stable;
    logic             stable_d;
    logic             armed;
    logic [CNT_W-1:0] db_cnt;
    logic             press_c;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] pre_cnt_nxt;
    logic             en_nxt;

    logic             cpu_en_q;
    logic [7:0]       count_q;

    // Two-flop synchronizers preset to idle levels; sync_ready marks when the
    // btn pipeline holds real samples rather than its reset preset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1     <= 1'b1;
            btn_s2     <= 1'b1;
            sw_s1      <= 1'b0;
            sw_s2      <= 1'b0;
            sync_ready <= 2'b00;
        end else begin
            btn_s1     <= bus.step_btn;
            btn_s2     <= btn_s1;
            sw_s1      <= bus.run_sw;
            sw_s2      <= sw_s1;
            sync_ready <= {sync_ready[0], 1'b1};
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is
    // accepted. Presses are armed only after a genuine release has been seen,
    // so a button held through reset does not fire on reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable   <= 1'b1;
            stable_d <= 1'b1;
            armed    <= 1'b0;
            db_cnt   <= '0;
        end else begin
            stable_d <= stable;
            if (sync_ready[1] && btn_s2 && stable) begin
                armed <= 1'b1;
            end
            if (btn_s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign press_c = armed & stable_d & ~stable;

    // Mode state and prescaler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_STEP;
            pre_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_cnt_nxt;
        end
    end

    // Next mode, prescaler and enable; halt overrides any pending pulse.
    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        en_nxt      = 1'b0;
        unique case (state)
            ST_STEP: begin
                if (bus.halt) begin
                    state_nxt = ST_HALTED;
                end else begin
                    en_nxt = press_c;
                    if (sw_s2) begin
                        state_nxt   = ST_RUN;
                        pre_cnt_nxt = '0;
                    end
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_nxt   = ST_HALTED;
                    pre_cnt_nxt = '0;
                end else if (!sw_s2) begin
                    state_nxt   = ST_STEP;
                    pre_cnt_nxt = '0;
                end else if (pre_cnt == RUN_LAST) begin
                    pre_cnt_nxt = '0;
                    en_nxt      = 1'b1;
                end else begin
                    pre_cnt_nxt = pre_cnt + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt   = ST_STEP;
                pre_cnt_nxt = '0;
            end
        endcase
        en_nxt = en_nxt & ~cpu_en_q;
    end

    // Registered enable pulse and wrapping pulse counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_en_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            cpu_en_q <= en_nxt;
            if (cpu_en_q) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.mode       = 2'(state);
    assign bus.step_count = count_q;

endmodule

// File: tb/tb_step_controller.sv
// Randomized scoreboard bench for step_controller with a behavioural model.
module tb_step_controller;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 5;

    localparam bit [1:0] M_STEP = 2'b00;
    localparam bit [1:0] M_RUN  = 2'b01;
    localparam bit [1:0] M_HALT = 2'b10;

    typedef struct {
        bit       en;
        bit [1:0] mode;
        bit [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    step_controller_if sc_if ();

    step_controller #(
        .DEBOUNCE_CYCLES (DB),
        .RUN_DIV         (RD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sc_if)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    // Behavioural model state: raw input pipelines, a sliding window of
    // synchronised button samples, and time spent in RUN mode.
    bit          btn_pipe[$];
    bit          sw_pipe[$];
    bit          db_win[$];
    int unsigned edge_n;
    int unsigned run_age;
    bit          m_stable;
    bit          m_armed;
    bit          m_pend;
    bit          m_en;
    bit [1:0]    m_mode;
    bit [7:0]    m_count;

    function automatic void model_reset();
        btn_pipe.delete();
        btn_pipe.push_back(1'b1);
        btn_pipe.push_back(1'b1);
        sw_pipe.delete();
        sw_pipe.push_back(1'b0);
        sw_pipe.push_back(1'b0);
        db_win.delete();
        edge_n   = 0;
        run_age  = 0;
        m_stable = 1'b1;
        m_armed  = 1'b0;
        m_pend   = 1'b0;
        m_en     = 1'b0;
        m_mode   = M_STEP;
        m_count  = 8'd0;
    endfunction

    function automatic void model_edge(input bit btn, input bit sw, input bit hlt);
        bit syn_btn;
        bit syn_sw;
        bit press;
        bit all_diff;
        syn_btn = btn_pipe.pop_front();
        btn_pipe.push_back(btn);
        syn_sw = sw_pipe.pop_front();
        sw_pipe.push_back(sw);
        edge_n++;
        press   = m_pend;
        m_count = m_count + 8'(m_en);
        if (m_mode == M_HALT) begin
            m_en = 1'b0;
        end else if (hlt) begin
            m_mode = M_HALT;
            m_en   = 1'b0;
        end else if (m_mode == M_STEP) begin
            m_en = press;
            if (syn_sw) begin
                m_mode  = M_RUN;
                run_age = 0;
            end
        end else if (!syn_sw) begin
            m_mode = M_STEP;
            m_en   = 1'b0;
        end else begin
            run_age++;
            m_en = ((run_age % RD) == 0);
        end
        // button accepted after DB consecutive synced samples at the new level
        if (edge_n >= 3 && syn_btn && m_stable) m_armed = 1'b1;
        db_win.push_back(syn_btn);
        if (db_win.size() > DB) void'(db_win.pop_front());
        m_pend = 1'b0;
        if (db_win.size() == DB) begin
            all_diff = 1'b1;
            foreach (db_win[i]) if (db_win[i] == m_stable) all_diff = 1'b0;
            if (all_diff) begin
                m_pend   = m_stable & m_armed;
                m_stable = ~m_stable;
                db_win.delete();
            end
        end
    endfunction

    // Model: one expected output record per clock edge (reset replaces it).
    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            model_reset();
            exp_q.delete();
        end else begin
            model_edge(sc_if.step_btn, sc_if.run_sw, sc_if.halt);
        end
        e.en   = m_en;
        e.mode = m_mode;
        e.cnt  = m_count;
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    bit prev_en = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty t=%0t no expectation for cpu_en=%b", $time, sc_if.cpu_en);
        end else begin
            e = exp_q.pop_front();
            if (sc_if.cpu_en !== e.en || sc_if.mode !== e.mode || sc_if.step_count !== e.cnt) begin
                miscompares++;
                $display("FAIL outputs t=%0t cpu_en got %b want %b, mode got %b want %b, step_count got %0d want %0d",
                         $time, sc_if.cpu_en, e.en, sc_if.mode, e.mode, sc_if.step_count, e.cnt);
            end
        end
        vectors++;
        if (prev_en && sc_if.cpu_en === 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back t=%0t cpu_en high on two consecutive cycles", $time);
        end
        prev_en = (sc_if.cpu_en === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int lo, input int hi);
        sc_if.step_btn = 1'b0;
        cyc(lo);
        sc_if.step_btn = 1'b1;
        cyc(hi);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    initial begin
        sc_if.step_btn = 1'b1;
        sc_if.run_sw   = 1'b0;
        sc_if.halt     = 1'b0;

        // reset, then idle
        cyc(3);
        rst = 1'b0;
        cyc(4);

        // clean press, then a short glitch
        press(10, 12);
        press(3, 10);

        // RUN for a while, then back to STEP
        sc_if.run_sw = 1'b1;
        cyc(29);
        sc_if.run_sw = 1'b0;
        cyc(10);

        // random presses with occasional run switch flips
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) sc_if.run_sw = ~sc_if.run_sw;
            press(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)));
        end
        sc_if.run_sw = 1'b0;
        cyc(6);

        // halt on the cycle before a RUN pulse, then try to wake it
        do_reset(2);
        cyc(4);
        sc_if.run_sw = 1'b1;
        cyc(7);
        sc_if.halt = 1'b1;
        cyc(1);
        sc_if.halt = 1'b0;
        repeat (3) press(6, 6);
        sc_if.run_sw = 1'b0;
        cyc(5);
        sc_if.run_sw = 1'b1;
        cyc(12);
        sc_if.run_sw = 1'b0;

        // 300 presses wrap the counter
        do_reset(2);
        cyc(3);
        repeat (300) press(5, 5);
        @(negedge clk);
        #1;
        vectors++;
        if (sc_if.step_count !== 8'd44) begin
            miscompares++;
            $display("FAIL wrap_count got %0d want 44", sc_if.step_count);
        end

        // reset while the button is held: no pulse until release and repress
        cyc(1);
        sc_if.step_btn = 1'b0;
        cyc(8);
        do_reset(2);
        cyc(15);
        sc_if.step_btn = 1'b1;
        cyc(10);
        press(6, 10);

        // reset in the middle of RUN counting
        sc_if.run_sw = 1'b1;
        cyc(9);
        do_reset(1);
        cyc(14);
        sc_if.run_sw = 1'b0;
        cyc(5);

        // fully random inputs including halts and resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) sc_if.step_btn = ~sc_if.step_btn;
            if ($urandom_range(0, 60) == 0) sc_if.run_sw = ~sc_if.run_sw;
            sc_if.halt = ($urandom_range(0, 250) == 0);
            if ($urandom_range(0, 200) == 0) do_reset(1);
            else cyc(1);
        end
        sc_if.halt   = 1'b0;
        sc_if.run_sw = 1'b0;
        cyc(4);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
